// File: rtl/bcd_adder_fnd_scan.sv
// bcd_adder_fnd_scan: multi-digit BCD adder with a common-anode FND scan driver.
//   The adder latches two packed-BCD operands on i_load. It then adds them one digit
//   per clock, least significant digit first, applying decimal correction. When the
//   last digit is done, the result is committed to a display register. The display
//   register is scanned onto a multiplexed 7-segment display.
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_a, i_b, i_cin         packed BCD operands (digit 0 at [3:0]) and carry-in
//   i_load                  start strobe, sampled only in IDLE
//   i_en                    display enable (0 blanks every digit)
//   o_busy, o_done          add in progress / one-cycle commit pulse
//   o_carry, o_err          committed decimal carry-out / invalid-digit flag
//   o_digit, o_fndFont      active-low digit enables / active-low {dp,g,f,e,d,c,b,a}
module bcd_adder_fnd_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000,
  parameter int LZB      = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [4*DIGITS-1:0]   i_a,
  input  logic [4*DIGITS-1:0]   i_b,
  input  logic                  i_cin,
  input  logic                  i_load,
  input  logic                  i_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_carry,
  output logic                  o_err,
  output logic [DIGITS-1:0]     o_digit,
  output logic [7:0]            o_fndFont
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] K_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, ADD} state_t;

  state_t                  state_q, state_d;
  logic [DIGITS-1:0][3:0]  a_q, b_q, shadow_q, disp_q, result;
  logic                    c_q, err_sh_q;
  logic [IW-1:0]           k_q;
  logic [4:0]              sum;
  logic [3:0]              sum_dig;
  logic                    sum_c, dig_err, last;

  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q, msnz;
  logic [7:0]              font_d;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // One digit slice of the adder. The correction is applied to the raw sum even when
  // the input is not valid BCD; validity is reported only through the err flag.
  always_comb begin
    sum     = {1'b0, a_q[k_q]} + {1'b0, b_q[k_q]} + {4'b0, c_q};
    sum_c   = (sum > 5'd9);
    sum_dig = sum_c ? (sum[3:0] + 4'd6) : sum[3:0];
    dig_err = (a_q[k_q] > 4'd9) || (b_q[k_q] > 4'd9);
    last    = (k_q == K_LAST);
    result  = shadow_q;
    // The commit happens on the same edge as the last digit. The display is therefore
    // loaded with the shadow register plus the digit being produced on this cycle.
    result[k_q] = sum_dig;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_load) state_d = ADD;
      ADD:     if (last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state_q == ADD);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      k_q      <= '0;
      err_sh_q <= 1'b0;
      shadow_q <= '0;
      disp_q   <= '0;
      o_carry  <= 1'b0;
      o_err    <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state_q <= state_d;
      o_done  <= 1'b0;
      case (state_q)
        IDLE: if (i_load) begin
          a_q      <= i_a;
          b_q      <= i_b;
          c_q      <= i_cin;
          k_q      <= '0;
          err_sh_q <= 1'b0;
          shadow_q <= '0;
        end
        ADD: begin
          shadow_q <= result;
          c_q      <= sum_c;
          err_sh_q <= err_sh_q | dig_err;
          k_q      <= k_q + 1'b1;
          if (last) begin
            disp_q  <= result;
            o_carry <= sum_c;
            o_err   <= err_sh_q | dig_err;
            o_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Font for the digit currently selected by the scan index.
  always_comb begin
    msnz = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (disp_q[i] != 4'd0) msnz = IW'(i);
    if (o_err)
      font_d = 8'hBF;
    else if ((LZB != 0) && (idx_q != '0) && (idx_q > msnz))
      font_d = 8'hFF;
    else
      font_d = seg7(disp_q[idx_q]);
    // The decimal point overrides blanking, so a blanked top digit still shows the carry.
    if (o_carry && (idx_q == K_LAST))
      font_d[7] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      o_digit   <= '1;
      o_fndFont <= 8'hFF;
    end else begin
      if (cnt_q == C_LAST) begin
        cnt_q <= '0;
        idx_q <= (idx_q == K_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (i_en) begin
        o_digit   <= ~(DIGITS'(1) << idx_q);
        o_fndFont <= font_d;
      end else begin
        o_digit   <= '1;
        o_fndFont <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_bcd_adder_fnd_scan.sv
module tb_bcd_adder_fnd_scan;
  localparam int D = 4;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0, load = 1'b0, en = 1'b1;

  logic [1:0]  busy, done, carry, err;
  logic [3:0]  dig [2];
  logic [7:0]  font [2];

  int errors = 0;
  int checks = 0;
  int n;

  int          exp_d [4];
  logic        exp_c, exp_e;
  logic [7:0]  font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  bcd_adder_fnd_scan #(.DIGITS(D), .SCAN_DIV(S), .LZB(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_a(a), .i_b(b), .i_cin(cin),
    .i_load(load), .i_en(en), .o_busy(busy[0]), .o_done(done[0]),
    .o_carry(carry[0]), .o_err(err[0]), .o_digit(dig[0]), .o_fndFont(font[0]));

  bcd_adder_fnd_scan #(.DIGITS(D), .SCAN_DIV(S), .LZB(1)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_a(a), .i_b(b), .i_cin(cin),
    .i_load(load), .i_en(en), .o_busy(busy[1]), .o_done(done[1]),
    .o_carry(carry[1]), .o_err(err[1]), .o_digit(dig[1]), .o_fndFont(font[1]));

  always #5 clk = ~clk;

  // Count of clock edges since the last reset release; the scan position follows from it.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else        n <= n + 1;

  // Reference result: plain decimal arithmetic for valid operands, otherwise the
  // digit-wise correction rule applied to the raw digit values.
  task automatic model_add(input logic [15:0] ma, input logic [15:0] mb, input logic mc);
    bit valid = 1'b1;
    int da = 0, db = 0, sum, c, s;
    for (int i = 0; i < 4; i++)
      if (ma[i*4 +: 4] > 4'd9 || mb[i*4 +: 4] > 4'd9) valid = 1'b0;
    if (valid) begin
      for (int i = 3; i >= 0; i--) begin
        da = da * 10 + int'(ma[i*4 +: 4]);
        db = db * 10 + int'(mb[i*4 +: 4]);
      end
      sum   = da + db + int'(mc);
      exp_c = (sum >= 10000);
      sum   = sum % 10000;
      for (int i = 0; i < 4; i++) begin
        exp_d[i] = sum % 10;
        sum      = sum / 10;
      end
    end else begin
      c = int'(mc);
      for (int i = 0; i < 4; i++) begin
        s = int'(ma[i*4 +: 4]) + int'(mb[i*4 +: 4]) + c;
        if (s > 9) begin exp_d[i] = (s + 6) % 16; c = 1; end
        else       begin exp_d[i] = s;            c = 0; end
      end
      exp_c = (c == 1);
    end
    exp_e = !valid;
  endtask

  function automatic logic [7:0] exp_font(input int j, input int lzb);
    int msnz = 0;
    logic [7:0] f;
    for (int i = 0; i < 4; i++) if (exp_d[i] != 0) msnz = i;
    if (exp_e)                          f = 8'hBF;
    else if (lzb == 1 && j > 0 && j > msnz) f = 8'hFF;
    else if (exp_d[j] > 9)              f = 8'hFF;
    else                                f = font_tab[exp_d[j]];
    if (exp_c && j == D - 1) f = f & 8'h7F;
    return f;
  endfunction

  task automatic check_scan(input string tag);
    int j;
    logic [3:0] ed;
    logic [7:0] ef;
    for (int c = 0; c < D * S; c++) begin
      @(negedge clk);
      j  = ((n - 1) / S) % D;
      ed = ~(4'd1 << j);
      for (int u = 0; u < 2; u++) begin
        ef = exp_font(j, u);
        checks++;
        if (dig[u] !== ed) begin
          errors++;
          $display("FAIL %s digit lzb=%0d n=%0d: got %b expected %b", tag, u, n, dig[u], ed);
        end
        checks++;
        if (font[u] !== ef) begin
          errors++;
          $display("FAIL %s font lzb=%0d j=%0d: got %h expected %h", tag, u, j, font[u], ef);
        end
      end
    end
  endtask

  // Starts an add and follows it through its busy cycles to the commit cycle.
  // With imm=1 the load is driven in the current cycle, so a call made right after a
  // previous add loads during that add's o_done cycle.
  task automatic do_add(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                        input bit imm, input string tag);
    if (!imm) @(negedge clk);
    a = va; b = vb; cin = vc; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    model_add(va, vb, vc);
    for (int i = 0; i < 4; i++) begin
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (busy[u] !== 1'b1 || done[u] !== 1'b0) begin
          errors++;
          $display("FAIL %s busy cycle %0d dut%0d: busy=%b done=%b expected busy=1 done=0",
                   tag, i, u, busy[u], done[u]);
        end
      end
      if (i < 3) @(negedge clk);
      else       @(negedge clk);
    end
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (busy[u] !== 1'b0 || done[u] !== 1'b1) begin
        errors++;
        $display("FAIL %s commit dut%0d: busy=%b done=%b expected busy=0 done=1",
                 tag, u, busy[u], done[u]);
      end
      checks++;
      if (carry[u] !== exp_c || err[u] !== exp_e) begin
        errors++;
        $display("FAIL %s flags dut%0d: carry=%b err=%b expected carry=%b err=%b",
                 tag, u, carry[u], err[u], exp_c, exp_e);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({busy[u], done[u], carry[u], err[u], dig[u], font[u]} !== {4'b0000, 4'b1111, 8'hFF}) begin
        errors++;
        $display("FAIL reset dut%0d: busy=%b done=%b carry=%b err=%b digit=%b font=%h expected 0 0 0 0 1111 ff",
                 u, busy[u], done[u], carry[u], err[u], dig[u], font[u]);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_d[i] = 0;
    exp_c = 1'b0; exp_e = 1'b0;
    check_scan("reset_display");
  endtask

  task automatic test_basic;
    do_add(16'h1234, 16'h5678, 1'b0, 0, "basic");
    check_scan("basic");
  endtask

  task automatic test_full_carry;
    do_add(16'h9999, 16'h0000, 1'b1, 0, "full_carry");
    check_scan("full_carry");
  endtask

  task automatic test_lzb;
    do_add(16'h0000, 16'h0042, 1'b0, 0, "lzb_42");
    check_scan("lzb_42");
    do_add(16'h0000, 16'h0000, 1'b0, 0, "lzb_zero");
    check_scan("lzb_zero");
  endtask

  task automatic test_invalid;
    do_add(16'h00A0, 16'h0001, 1'b0, 0, "invalid");
    check_scan("invalid");
    do_add(16'h0150, 16'h0007, 1'b0, 0, "invalid_clear");
    check_scan("invalid_clear");
  endtask

  task automatic test_busy_load;
    @(negedge clk);
    a = 16'h5555; b = 16'h4445; cin = 1'b0; load = 1'b1;
    @(negedge clk);                      // after E0
    load = 1'b0;
    @(negedge clk);                      // after E1
    a = 16'h1111; b = 16'h1111; load = 1'b1;
    @(negedge clk);                      // after E2: the extra load has been sampled
    load = 1'b0;
    model_add(16'h5555, 16'h4445, 1'b0);
    @(negedge clk);                      // after E3
    @(negedge clk);                      // after E4
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (done[u] !== 1'b1 || carry[u] !== 1'b1) begin
        errors++;
        $display("FAIL busy_load commit dut%0d: done=%b carry=%b expected done=1 carry=1",
                 u, done[u], carry[u]);
      end
    end
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (busy[u] !== 1'b0) begin
        errors++;
        $display("FAIL busy_load restart dut%0d: busy=%b expected 0", u, busy[u]);
      end
    end
    check_scan("busy_load");
  endtask

  task automatic test_back_to_back;
    do_add(16'h0809, 16'h0102, 1'b1, 0, "b2b_first");
    do_add(16'h4321, 16'h2345, 1'b0, 1, "b2b_second");
    check_scan("b2b");
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({busy[u], done[u], carry[u], err[u], dig[u], font[u]} !== {4'b0000, 4'b1111, 8'hFF}) begin
        errors++;
        $display("FAIL reset_mid dut%0d: busy=%b done=%b carry=%b err=%b digit=%b font=%h expected 0 0 0 0 1111 ff",
                 u, busy[u], done[u], carry[u], err[u], dig[u], font[u]);
      end
    end
    for (int i = 0; i < 4; i++) exp_d[i] = 0;
    exp_c = 1'b0; exp_e = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_scan("reset_mid");
  endtask

  task automatic test_disable;
    do_add(16'h2468, 16'h7531, 1'b1, 0, "disable_setup");
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (dig[u] !== 4'b1111 || font[u] !== 8'hFF) begin
          errors++;
          $display("FAIL disable dut%0d: digit=%b font=%h expected 1111 ff", u, dig[u], font[u]);
        end
      end
    end
    en = 1'b1;
    check_scan("reenable");
  endtask

  task automatic test_random;
    logic [15:0] ra, rb;
    int pos;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 4; i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(0, 9));
        rb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if (it % 4 == 3) begin
        pos = $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 0) ra[pos*4 +: 4] = 4'($urandom_range(10, 15));
        else                           rb[pos*4 +: 4] = 4'($urandom_range(10, 15));
      end
      do_add(ra, rb, 1'($urandom_range(0, 1)), 0, "random");
      check_scan("random");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full_carry;
    test_lzb;
    test_invalid;
    test_busy_load;
    test_back_to_back;
    test_reset_mid;
    test_disable;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
